store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 124 ++++++++++++
 tb/tb_store_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and data memory. Stores are queued in a
// circular FIFO and drained one at a time by a three-state FSM; loads are only
// let through once the buffer is empty and the drain FSM is idle, so memory
// always sees accesses in program order.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              cpu_addr,
   input  logic [31:0]              cpu_write_data,
   input  logic                     cpu_memwrite,
   input  logic                     cpu_memread,
   input  logic [3:0]               cpu_sign_mask,
   output logic                     cpu_stall,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_write_data,
   output logic [3:0]               mem_sign_mask,
   output logic                     mem_memwrite,
   output logic                     mem_memread,
   input  logic                     mem_clk_stall,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_BUSY} drain_state_t;

   drain_state_t state_q, state_d;

   logic [31:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [3:0]    mask_mem [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic full, empty, push, pop, load_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   // A full buffer refuses the push even when the head is popped this cycle.
   assign push  = cpu_memwrite & ~full;
   assign pop   = (state_q == D_ISSUE);
   // rst_n gating keeps the read strobe low while reset is held.
   assign load_ok = rst_n & cpu_memread & ~cpu_memwrite & empty & (state_q == D_IDLE);

   assign sb_count = count_q;

   // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is 2^n.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and drain-state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= D_IDLE;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   // Entry storage; contents are don't-care until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_q] <= cpu_addr;
         data_mem[tail_q] <= cpu_write_data;
         mask_mem[tail_q] <= cpu_sign_mask;
      end
   end

   // Drain FSM: issue the head entry, wait for memory to commit, then idle a cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         D_IDLE:  if (!empty) state_d = D_ISSUE;
         D_ISSUE: state_d = D_BUSY;
         D_BUSY:  if (mem_clk_stall) state_d = D_IDLE;
         default: state_d = D_IDLE;
      endcase
   end

   // Memory request mux and CPU stall; the memory side follows the CPU when idle.
   always_comb begin
      mem_memwrite   = 1'b0;
      mem_memread    = 1'b0;
      mem_addr       = cpu_addr;
      mem_write_data = cpu_write_data;
      mem_sign_mask  = cpu_sign_mask;
      cpu_stall      = 1'b0;
      if (state_q == D_ISSUE) begin
         mem_memwrite   = 1'b1;
         mem_addr       = addr_mem[head_q];
         mem_write_data = data_mem[head_q];
         mem_sign_mask  = mask_mem[head_q];
      end else if (load_ok) begin
         mem_memread = 1'b1;
      end
      if (cpu_memwrite) begin
         cpu_stall = full;
      end else if (cpu_memread) begin
         cpu_stall = rst_n & ~load_ok;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer. A small data-memory model commits writes and
// raises mem_clk_stall for one cycle, LAT cycles after each write strobe.
module tb_store_buffer;

   localparam logic [3:0] MASK_WORD = 4'b0010;  // bench-local size encoding
   localparam logic [3:0] MASK_BYTE = 4'b0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_write_data = '0;
   logic        cpu_memwrite = 1'b0, cpu_memread = 1'b0;
   logic [3:0]  cpu_sign_mask = '0;
   logic        cpu_stall;
   logic [31:0] mem_addr, mem_write_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memwrite, mem_memread, mem_clk_stall;
   logic [2:0]  sb_count;

   int vecs = 0;
   int errs = 0;

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
      .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread), .cpu_sign_mask(cpu_sign_mask),
      .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_sign_mask(mem_sign_mask), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_clk_stall(mem_clk_stall), .sb_count(sb_count)
   );

   always #5 clk = ~clk;

   // ---------------- data-memory model ----------------
   logic [31:0] mem_model [int unsigned];
   logic [31:0] wr_addr_log [$];
   logic [31:0] wr_data_log [$];
   int unsigned lat = 1;
   int unsigned busy_cnt = 0;
   int both_cnt = 0;

   assign mem_clk_stall = (busy_cnt == 1);

   function automatic logic [31:0] mem_load(input logic [31:0] a);
      int unsigned k = int'(a >> 2);
      if (mem_model.exists(k)) return mem_model[k];
      return 32'h0;
   endfunction

   function automatic void mem_store(input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] m);
      logic [31:0] w;
      int lane;
      int unsigned k = int'(a >> 2);
      if (m == MASK_BYTE) begin
         w = mem_load(a);
         lane = int'(a[1:0]);
         w[lane*8 +: 8] = d[7:0];
         mem_model[k] = w;
      end else begin
         mem_model[k] = d;
      end
   endfunction

   always @(posedge clk) begin
      if (mem_memwrite && mem_memread) both_cnt++;
      if (mem_memwrite) begin
         wr_addr_log.push_back(mem_addr);
         wr_data_log.push_back(mem_write_data);
         mem_store(mem_addr, mem_write_data, mem_sign_mask);
         busy_cnt <= lat;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
      cpu_memwrite = 1'b1; cpu_memread = 1'b0;
   endtask

   task automatic set_load(input logic [31:0] a, input logic [3:0] m);
      cpu_addr = a; cpu_sign_mask = m; cpu_memwrite = 1'b0; cpu_memread = 1'b1;
   endtask

   task automatic set_none();
      cpu_memwrite = 1'b0; cpu_memread = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      vecs++;
      if ({cpu_stall, mem_memwrite, mem_memread, sb_count} !== 6'b0) begin
         errs++;
         $display("FAIL reset_state: got stall/wr/rd/count=%b/%b/%b/%0d want 0/0/0/0",
                  cpu_stall, mem_memwrite, mem_memread, sb_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_store();
      @(negedge clk);
      set_store(32'h100, 32'hDEADBEEF, MASK_WORD);
      #1; vecs++;
      if (cpu_stall !== 1'b0) begin
         errs++; $display("FAIL single_accept: stall=%b want 0", cpu_stall);
      end
      @(negedge clk);
      set_none();
      #1; vecs++;
      if ({mem_memwrite, sb_count} !== {1'b0, 3'd1}) begin
         errs++; $display("FAIL single_idle: wr=%b count=%0d want 0/1", mem_memwrite, sb_count);
      end
      // The idle cycle sees the entry, the following cycle issues it.
      @(negedge clk); #1; vecs++;
      if ({mem_memwrite, mem_addr, mem_write_data, mem_sign_mask} !==
          {1'b1, 32'h100, 32'hDEADBEEF, MASK_WORD}) begin
         errs++;
         $display("FAIL single_issue: wr=%b addr=%h data=%h mask=%b want 1/100/deadbeef/%b",
                  mem_memwrite, mem_addr, mem_write_data, mem_sign_mask, MASK_WORD);
      end
      @(negedge clk); #1; vecs++;
      if ({mem_memwrite, mem_memread, sb_count} !== 5'b0) begin
         errs++;
         $display("FAIL single_busy: wr=%b rd=%b count=%0d want 0/0/0",
                  mem_memwrite, mem_memread, sb_count);
      end
      @(negedge clk);
      set_load(32'h100, MASK_WORD);
      #1; vecs++;
      if ({cpu_stall, mem_memread, mem_addr} !== {1'b0, 1'b1, 32'h100} ||
          mem_load(mem_addr) !== 32'hDEADBEEF) begin
         errs++;
         $display("FAIL single_readback: stall=%b rd=%b addr=%h data=%h want 0/1/100/deadbeef",
                  cpu_stall, mem_memread, mem_addr, mem_load(mem_addr));
      end
      @(negedge clk);
      set_none();
   endtask

   task automatic test_load_empty();
      logic [31:0] addrs [3];
      logic [3:0]  masks [3];
      addrs[0] = 32'h0000_0040; addrs[1] = 32'h1234_5678; addrs[2] = 32'hFFFF_FFFC;
      masks[0] = MASK_WORD;     masks[1] = MASK_BYTE;     masks[2] = 4'b1011;
      @(negedge clk);
      cpu_addr = 32'hCAFE_0000; cpu_sign_mask = 4'b0101;
      #1; vecs++;
      if ({mem_memwrite, mem_memread, mem_addr} !== {2'b00, 32'hCAFE_0000}) begin
         errs++;
         $display("FAIL idle_passthru: wr=%b rd=%b addr=%h want 0/0/cafe0000",
                  mem_memwrite, mem_memread, mem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_load(addrs[i], masks[i]);
         #1; vecs++;
         if ({cpu_stall, mem_memread, mem_memwrite, mem_addr, mem_sign_mask} !==
             {1'b0, 1'b1, 1'b0, addrs[i], masks[i]}) begin
            errs++;
            $display("FAIL load_empty[%0d]: stall=%b rd=%b wr=%b addr=%h mask=%b want 0/1/0/%h/%b",
                     i, cpu_stall, mem_memread, mem_memwrite, mem_addr, mem_sign_mask,
                     addrs[i], masks[i]);
         end
      end
      @(negedge clk);
      set_none();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea [6];
      logic [31:0] ed [6];
      int base, found, stalls;
      ea[0] = 32'h500; ea[1] = 32'h504; ea[2] = 32'h0000_2000;
      ea[3] = 32'h508; ea[4] = 32'h50C; ea[5] = 32'h510;
      for (int i = 0; i < 6; i++) ed[i] = 32'hA0 + 32'(i);
      lat = 8;
      base = wr_addr_log.size();
      @(negedge clk);
      set_store(ea[0], ed[0], MASK_WORD);
      @(negedge clk);
      set_none();
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(negedge clk); #1;
         if (mem_memwrite) found = 1;
      end
      vecs++;
      if (found == 0) begin
         errs++; $display("FAIL b2b_first_issue: wr=%b want 1 within 10 cycles", mem_memwrite);
      end
      // Memory is now busy for 8 cycles: four stores fill the buffer.
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         set_store(ea[i], ed[i], MASK_WORD);
         #1; vecs++;
         if (cpu_stall !== 1'b0) begin
            errs++; $display("FAIL b2b_accept[%0d]: stall=%b want 0", i, cpu_stall);
         end
      end
      @(negedge clk);
      set_store(ea[5], ed[5], MASK_WORD);
      #1;
      stalls = 0;
      while (cpu_stall && stalls < 20) begin
         stalls++;
         @(negedge clk); #1;
      end
      // Busy 4 more cycles, idle, issue (pop, still full): 6 stalled cycles.
      vecs++;
      if (stalls != 6) begin
         errs++; $display("FAIL b2b_full_stall: stalled %0d cycles want 6", stalls);
      end
      @(negedge clk);
      set_none();
      repeat (60) @(negedge clk);
      vecs++;
      if (wr_addr_log.size() - base != 6 || sb_count !== 3'd0) begin
         errs++;
         $display("FAIL b2b_drain_count: writes=%0d count=%0d want 6/0",
                  wr_addr_log.size() - base, sb_count);
      end else begin
         for (int i = 0; i < 6; i++) begin
            vecs++;
            if (wr_addr_log[base+i] !== ea[i] || wr_data_log[base+i] !== ed[i]) begin
               errs++;
               $display("FAIL b2b_order[%0d]: got %h<-%h want %h<-%h", i,
                        wr_addr_log[base+i], wr_data_log[base+i], ea[i], ed[i]);
            end
         end
      end
      lat = 1;
   endtask

   task automatic load_after_store(input string name, input logic [31:0] sa,
                                   input logic [31:0] sd, input logic [3:0] sm,
                                   input logic [31:0] la, input logic [31:0] want);
      int stalls;
      logic bad_rd;
      @(negedge clk);
      set_store(sa, sd, sm);
      #1; vecs++;
      if (cpu_stall !== 1'b0) begin
         errs++; $display("FAIL %s_store: stall=%b want 0", name, cpu_stall);
      end
      @(negedge clk);
      set_load(la, MASK_WORD);
      #1;
      stalls = 0; bad_rd = 1'b0;
      while (cpu_stall && stalls < 20) begin
         if (mem_memread !== 1'b0) bad_rd = 1'b1;
         stalls++;
         @(negedge clk); #1;
      end
      // Idle (count 1), issue, busy, then accepted in the next idle cycle.
      vecs++;
      if (stalls != 3 || bad_rd) begin
         errs++;
         $display("FAIL %s_stall: stalled %0d cycles rd_while_stalled=%b want 3/0",
                  name, stalls, bad_rd);
      end
      vecs++;
      if ({mem_memread, mem_addr} !== {1'b1, la} || mem_load(mem_addr) !== want) begin
         errs++;
         $display("FAIL %s_data: rd=%b addr=%h data=%h want 1/%h/%h",
                  name, mem_memread, mem_addr, mem_load(mem_addr), la, want);
      end
      @(negedge clk);
      set_none();
   endtask

   task automatic test_load_after_store();
      load_after_store("raw", 32'h200, 32'h11, MASK_WORD, 32'h200, 32'h11);
   endtask

   task automatic test_byte_store();
      load_after_store("byte", 32'h303, 32'hAB, MASK_BYTE, 32'h300, 32'hAB00_0000);
   endtask

   task automatic test_store_and_load();
      @(negedge clk);
      set_store(32'h600, 32'h66, MASK_WORD);
      cpu_memread = 1'b1;
      #1; vecs++;
      if ({cpu_stall, mem_memread} !== 2'b00) begin
         errs++; $display("FAIL wr_rd_both: stall=%b rd=%b want 0/0", cpu_stall, mem_memread);
      end
      @(negedge clk);
      set_none();
      #1; vecs++;
      if (sb_count !== 3'd1) begin
         errs++; $display("FAIL wr_rd_pushed: count=%0d want 1", sb_count);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid_drain();
      int nw;
      lat = 4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_store(32'h700 + 32'(4*i), 32'h70 + 32'(i), MASK_WORD);
      end
      @(negedge clk);
      set_load(32'h700, MASK_WORD);
      #1; vecs++;
      if ({mem_memwrite, sb_count} !== {1'b0, 3'd2}) begin
         errs++; $display("FAIL rst_pre_busy: wr=%b count=%0d want 0/2", mem_memwrite, sb_count);
      end
      #2 rst_n = 1'b0;
      nw = wr_addr_log.size();
      #1; vecs++;
      if ({cpu_stall, mem_memwrite, mem_memread, sb_count} !== 6'b0) begin
         errs++;
         $display("FAIL rst_async: stall/wr/rd/count=%b/%b/%b/%0d want 0/0/0/0",
                  cpu_stall, mem_memwrite, mem_memread, sb_count);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_none();
      repeat (20) @(negedge clk);
      vecs++;
      if (wr_addr_log.size() != nw || sb_count !== 3'd0) begin
         errs++;
         $display("FAIL rst_discard: writes_after=%0d count=%0d want 0/0",
                  wr_addr_log.size() - nw, sb_count);
      end
      lat = 1;
   endtask

   task automatic test_exclusive_strobes();
      vecs++;
      if (both_cnt != 0) begin
         errs++; $display("FAIL strobes_exclusive: both-high cycles=%0d want 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_load_empty();
      test_back_to_back();
      test_load_after_store();
      test_byte_store();
      test_store_and_load();
      test_reset_mid_drain();
      test_exclusive_strobes();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
